// File: rtl/instr_enc_loader.sv
// Instruction-memory loader: accepts MIPS field sets, encodes them as R/I/J words
// and writes them to consecutive word addresses with a write/ack handshake.
module instr_enc_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        last_q;
    logic [31:0] enc;
    logic        fmt_ok;
    logic        at_top;

    assign fmt_ok = (fmt != 2'b11);
    assign at_top = (wr_addr == 8'hFF);

    always_comb begin
        enc = '0;
        case (fmt)
            2'b00:   enc = {op, rs, rt, rd, shamt, func};
            2'b01:   enc = {op, rs, rt, imm16};
            2'b10:   enc = {op, addr26};
            default: enc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs decode from state alone so reset clears them without a clock edge.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (fmt_ok)       next_state = WRITE;
                    else if (in_last) next_state = DONE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (wr_ack) next_state = (last_q || at_top) ? DONE : LOAD;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= '0;
            count   <= '0;
            err     <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_addr <= '0;
                        count   <= '0;
                        err     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (fmt_ok) begin
                            wr_data <= enc;
                            last_q  <= in_last;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        count <= count + 9'd1;
                        // Address saturates at the top; running out of space without a last word is an error.
                        if (!last_q) begin
                            if (at_top) err     <= 1'b1;
                            else        wr_addr <= wr_addr + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed self-checking bench for instr_enc_loader: table of single-word sessions
// plus hand-written multi-word, backpressure, illegal-format, full-memory and reset sequences.
module tb_instr_enc_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        in_valid, in_last, in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        busy, done, err;
    logic [8:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  func;
        logic [15:0] imm16;
        logic [25:0] addr26;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];
    vec_t v_i, v_j, v_bad;

    instr_enc_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fmt(fmt), .op(op),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .imm16(imm16), .addr26(addr26), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [1:0] f, logic [5:0] o, logic [4:0] s, logic [4:0] t,
                                logic [4:0] d, logic [4:0] h, logic [5:0] fn,
                                logic [15:0] im, logic [25:0] ad, logic [31:0] e);
        vec_t v;
        v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.shamt = h;
        v.func = fn; v.imm16 = im; v.addr26 = ad; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        fmt = v.fmt; op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
        func = v.func; imm16 = v.imm16; addr26 = v.addr26;
    endtask

    // All bench actions happen 1 time unit after a rising edge.
    task automatic start_session();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic last);
        int n = 0;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic ack(input int delay);
        logic [7:0]  a;
        logic [31:0] d;
        a = wr_addr;
        d = wr_data;
        for (int i = 0; i < delay; i++) begin
            wr_ack = 1'b0;
            @(posedge clk); #1;
            check("bp_wr_en", wr_en, 1);
            check("bp_wr_addr", wr_addr, a);
            check("bp_wr_data", wr_data, d);
            check("bp_in_ready", in_ready, 0);
        end
        wr_ack = 1'b1;
        @(posedge clk); #1;
        wr_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(2'b00, 6'h00, 5'd8,  5'd9,  5'd10, 5'd0,  6'h20, 16'hBEEF, 26'h0,       32'h01095020);
        vecs[1] = mk(2'b00, 6'h00, 5'd0,  5'd9,  5'd8,  5'd4,  6'h00, 16'h0,    26'h0,       32'h00094100);
        vecs[2] = mk(2'b00, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0,    26'h0,       32'hFFFFFFFF);
        vecs[3] = mk(2'b01, 6'h23, 5'd29, 5'd8,  5'd31, 5'd31, 6'h3F, 16'h0004, 26'h3FFFFFF, 32'h8FA80004);
        vecs[4] = mk(2'b01, 6'h08, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h2022FFFF);
        vecs[5] = mk(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000);
        vecs[6] = mk(2'b10, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0,    26'h3FFFFFF, 32'h0FFFFFFF);
        v_i   = vecs[3];
        v_j   = vecs[5];
        v_bad = mk(2'b11, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h1234, 26'h0, 32'h0);

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; wr_ack = 1'b0;
        apply(vecs[0]);
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_no_start", in_ready, 0);

        // Table: one-word sessions, one per encoding vector.
        for (int k = 0; k < 7; k++) begin
            start_session();
            apply(vecs[k]);
            send(1'b1);
            check("vec_wr_en", wr_en, 1);
            check("vec_wr_data", wr_data, vecs[k].exp);
            check("vec_wr_addr", wr_addr, 0);
            check("vec_in_ready", in_ready, 0);
            check("vec_busy", busy, 1);
            ack(0);
            check("vec_done", done, 1);
            check("vec_count", count, 1);
            check("vec_err", err, 0);
            check("vec_busy_done", busy, 0);
            check("vec_wr_en_done", wr_en, 0);
            @(posedge clk); #1;
            check("vec_done_pulse", done, 0);
        end

        // I then J, with an idle LOAD stretch, a stray start, and write backpressure.
        start_session();
        apply(v_i);
        send(1'b0);
        check("ij_data0", wr_data, 32'h8FA80004);
        check("ij_addr0", wr_addr, 0);
        ack(0);
        check("ij_back_load", in_ready, 1);
        check("ij_addr1", wr_addr, 1);
        check("ij_count1", count, 1);
        start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b0;
        check("hold_in_ready", in_ready, 1);
        check("hold_addr", wr_addr, 1);
        check("hold_count", count, 1);
        apply(v_j);
        send(1'b1);
        check("ij_data1", wr_data, 32'h08100000);
        check("ij_addr1w", wr_addr, 1);
        ack(3);
        check("bp_done", done, 1);
        check("bp_wr_en_after", wr_en, 0);
        check("ij_count2", count, 2);
        check("ij_err", err, 0);
        wr_ack = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        wr_ack = 1'b0;
        check("stray_ack_count", count, 2);
        check("stray_ack_wr_en", wr_en, 0);

        // Illegal format mid-session.
        start_session();
        apply(vecs[0]);
        send(1'b0);
        ack(0);
        apply(v_bad);
        send(1'b0);
        check("ill_wr_en", wr_en, 0);
        check("ill_err", err, 1);
        check("ill_count", count, 1);
        check("ill_in_ready", in_ready, 1);
        apply(vecs[4]);
        send(1'b1);
        check("ill_next_addr", wr_addr, 1);
        check("ill_next_data", wr_data, 32'h2022FFFF);
        ack(0);
        check("ill_done", done, 1);
        check("ill_count2", count, 2);
        check("ill_err_sticky", err, 1);
        @(posedge clk); #1;
        check("ill_err_hold", err, 1);
        start_session();
        check("restart_err_clr", err, 0);
        check("restart_count_clr", count, 0);
        apply(v_bad);
        send(1'b1);
        check("ill_last_done", done, 1);
        check("ill_last_count", count, 0);
        check("ill_last_err", err, 1);
        @(posedge clk); #1;

        // Fill all 256 words without in_last.
        start_session();
        check("full_addr_clr", wr_addr, 0);
        for (int i = 0; i < 256; i++) begin
            apply(mk(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'(i), 32'h0));
            send(1'b0);
            check("full_addr", wr_addr, i);
            check("full_data", wr_data, 32'h08000000 | 32'(i));
            ack(0);
        end
        check("full_done", done, 1);
        check("full_count", count, 256);
        check("full_err", err, 1);
        check("full_addr_top", wr_addr, 255);
        @(posedge clk); #1;

        // Reset mid-WRITE with wr_ack low.
        start_session();
        apply(vecs[1]);
        send(1'b0);
        ack(0);
        apply(vecs[2]);
        send(1'b0);
        check("prer_wr_en", wr_en, 1);
        check("prer_count", count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_wr_en", wr_en, 0);
        check("ar_busy", busy, 0);
        check("ar_count", count, 0);
        check("ar_wr_addr", wr_addr, 0);
        check("ar_wr_data", wr_data, 0);
        check("ar_in_ready", in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle", in_ready | busy | wr_en, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
